mlp_train_sequencer: RTL

Upstream stimulus/control stage for the MLP core. It replays a boolean truth table as fixed-point training samples for a bounded number of epochs and scores each prediction against the target. It stops early when an epoch is fully correct, then switches to inference. In inference it drives the MLP inputs from synchronised, debounced board switches and drives the result LED.

---
 rtl/mlp_train_sequencer_pkg.sv | 26 ++
 rtl/mlp_train_sequencer_switch_debouncer.sv | 44 ++++
 rtl/mlp_train_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mlp_train_sequencer_pkg.sv
// Shared fixed-point types and sequencer state encoding for the MLP training sequencer.
// The state enum lives here so that benches can name the states directly.
package mlp_train_sequencer_pkg;

  localparam int SFP_W    = 16;
  localparam int SFP_FRAC = 8;

  typedef logic signed [SFP_W-1:0] sfp;

  localparam sfp ONE  = 16'sh0100;
  localparam sfp HALF = 16'sh0080;

  typedef enum logic [2:0] {
    IDLE,
    PRESENT,
    SETTLE,
    CHECK,
    NEXT,
    INFER
  } seq_state_e;

  function automatic sfp bit_to_sfp(input logic b);
    return b ? ONE : '0;
  endfunction

endpackage

// File: rtl/mlp_train_sequencer_switch_debouncer.sv
// Board switch conditioning: a 2-flop synchroniser per bit, then a per-bit stability counter.
// The clean bit only flips after the synchronised value has differed for DEBOUNCE_CYCLES cycles.
module switch_debouncer #(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] clean
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [CW-1:0]    cnt [WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      clean <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] != clean[i]) begin
          if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
            clean[i] <= sync2[i];
            cnt[i]   <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          // any return to the accepted value restarts the stability window
          cnt[i] <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/mlp_train_sequencer.sv
// Replays a truth table as fixed-point training samples, scores each prediction, stops on a
// fully correct epoch or after MAX_EPOCHS, then drives the MLP from debounced switches.
//
// state   | meaning
// IDLE    | after reset, all outputs zero, waiting for start
// PRESENT | drive values/expected for the current row, load settle counter
// SETTLE  | hold the sample for SETTLE_CYCLES cycles
// CHECK   | score prediction against the row target
// NEXT    | advance row, or close the epoch and decide retrain/stop
// INFER   | inference from switches, led shows the predicted class
module mlp_train_sequencer
  import mlp_train_sequencer_pkg::*;
#(
  parameter int                       INPUTS          = 2,
  parameter logic [(1<<INPUTS)-1:0]   TRUTH_TABLE     = 4'b1000,
  parameter int                       MAX_EPOCHS      = 10,
  parameter int                       SETTLE_CYCLES   = 4,
  parameter int                       DEBOUNCE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [INPUTS-1:0] sw,
  input  sfp                prediction,
  output sfp                values [INPUTS],
  output sfp                expected,
  output logic              training,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic [7:0]        epoch_count,
  output logic [INPUTS:0]   epoch_correct,
  output logic              led
);

  localparam int ROWS = 1 << INPUTS;
  localparam int SCW  = $clog2(SETTLE_CYCLES + 1);

  seq_state_e        state;
  logic [INPUTS-1:0] row;
  logic [INPUTS:0]   correct;
  logic [SCW-1:0]    settle_cnt;
  logic [INPUTS-1:0] clean;

  logic [INPUTS-1:0] row_inc;
  logic [7:0]        epoch_inc;
  logic              pred_high;
  logic              hit;

  assign row_inc   = row + 1'b1;
  assign epoch_inc = epoch_count + 8'd1;
  // signed strict compare over the full width: exactly HALF is class 0
  assign pred_high = (prediction > HALF);
  assign hit       = (pred_high == TRUTH_TABLE[row]);

  switch_debouncer #(
    .WIDTH           (INPUTS),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .raw   (sw),
    .clean (clean)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      row           <= '0;
      correct       <= '0;
      settle_cnt    <= '0;
      for (int k = 0; k < INPUTS; k++) values[k] <= '0;
      expected      <= '0;
      training      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      converged     <= 1'b0;
      epoch_count   <= '0;
      epoch_correct <= '0;
      led           <= 1'b0;
    end else if ((state == IDLE || state == INFER) && start) begin
      state         <= PRESENT;
      row           <= '0;
      correct       <= '0;
      epoch_count   <= '0;
      epoch_correct <= '0;
      converged     <= 1'b0;
      busy          <= 1'b1;
      training      <= 1'b1;
      done          <= 1'b0;
      led           <= 1'b0;
      for (int k = 0; k < INPUTS; k++) values[k] <= '0;
      expected      <= bit_to_sfp(TRUTH_TABLE[0]);
    end else begin
      case (state)
        IDLE: ;
        PRESENT: begin
          settle_cnt <= SCW'(SETTLE_CYCLES - 1);
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == '0) state <= CHECK;
          else                  settle_cnt <= settle_cnt - 1'b1;
        end
        CHECK: begin
          if (hit) correct <= correct + 1'b1;
          state <= NEXT;
        end
        NEXT: begin
          if (row != INPUTS'(ROWS - 1)) begin
            row <= row_inc;
            for (int k = 0; k < INPUTS; k++) values[k] <= bit_to_sfp(row_inc[k]);
            expected <= bit_to_sfp(TRUTH_TABLE[row_inc]);
            state    <= PRESENT;
          end else begin
            epoch_count   <= epoch_inc;
            epoch_correct <= correct;
            if (correct == (INPUTS+1)'(ROWS) || epoch_inc == 8'(MAX_EPOCHS)) begin
              converged <= (correct == (INPUTS+1)'(ROWS));
              training  <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              led       <= 1'b0;
              for (int k = 0; k < INPUTS; k++) values[k] <= bit_to_sfp(clean[k]);
              expected  <= '0;
              state     <= INFER;
            end else begin
              row     <= '0;
              correct <= '0;
              for (int k = 0; k < INPUTS; k++) values[k] <= '0;
              expected <= bit_to_sfp(TRUTH_TABLE[0]);
              state    <= PRESENT;
            end
          end
        end
        INFER: begin
          for (int k = 0; k < INPUTS; k++) values[k] <= bit_to_sfp(clean[k]);
          expected <= '0;
          led      <= pred_high;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
